// File: rtl/fv_fifo_drain.sv
// Read-side drain controller for the FV info FIFO: pops a commanded burst of entries
// and streams them downstream through a 2-entry skid buffer that absorbs the read latency.
module fv_fifo_drain #(
    parameter int unsigned LEN_W  = 16,
    parameter int unsigned DATA_W = 32  // $bits(FV_info2FV_FIFO)
) (
    input  logic              wclk,
    input  logic              rst,
    input  logic              i_cmd_valid,
    input  logic [LEN_W-1:0]  i_cmd_len,
    output logic              o_cmd_ready,
    input  logic              i_fifo_rempty,
    output logic              o_fifo_rinc,
    input  logic [DATA_W-1:0] i_fifo_rdata,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [DATA_W-1:0] o_out_data,
    output logic              o_busy,
    output logic              o_done,
    output logic [LEN_W-1:0]  o_drained_cnt
);

    localparam int unsigned BUF_DEPTH = 2;

    typedef enum logic [1:0] {
        StIdle,
        StDrain,
        StDone
    } state_e;

    state_e              r_state;
    logic [LEN_W-1:0]    r_len;
    logic [LEN_W-1:0]    r_issued;
    logic [LEN_W-1:0]    r_drained;
    logic                r_inflight;
    logic [DATA_W-1:0]   r_buf [BUF_DEPTH];
    logic                r_head;
    logic [1:0]          r_buf_cnt;

    logic                w_pop;
    logic                w_rinc;
    logic                w_wptr;
    logic [2:0]          w_occ;

    always_comb begin
        w_pop  = (r_buf_cnt != 2'd0) & i_out_ready;
        // Credit: buffered + in-flight entries after this cycle's pop must leave room.
        w_occ  = 3'(r_buf_cnt) + 3'(r_inflight) - 3'(w_pop);
        w_rinc = (r_state == StDrain) & ~i_fifo_rempty & (r_issued < r_len)
                 & (w_occ < 3'(BUF_DEPTH));
        // An arriving read always finds buf_cnt <= 1, so the tail is head ^ cnt[0].
        w_wptr = r_head ^ r_buf_cnt[0];
    end

    always_ff @(posedge wclk) begin
        if (rst) begin
            r_state    <= StIdle;
            r_len      <= '0;
            r_issued   <= '0;
            r_drained  <= '0;
            r_inflight <= 1'b0;
            r_head     <= 1'b0;
            r_buf_cnt  <= 2'd0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            r_inflight <= w_rinc;
            if (r_inflight) begin
                r_buf[w_wptr] <= i_fifo_rdata;
            end
            r_head    <= r_head ^ w_pop;
            r_buf_cnt <= r_buf_cnt + {1'b0, r_inflight} - {1'b0, w_pop};
            if (w_rinc) begin
                r_issued <= r_issued + LEN_W'(1);
            end
            if (w_pop) begin
                r_drained <= r_drained + LEN_W'(1);
            end

            unique case (r_state)
                StIdle: begin
                    if (i_cmd_valid) begin
                        r_len     <= i_cmd_len;
                        r_issued  <= '0;
                        r_drained <= '0;
                        r_state   <= (i_cmd_len != '0) ? StDrain : StDone;
                    end
                end
                StDrain: begin
                    if (w_pop && (r_drained == r_len - LEN_W'(1))) begin
                        r_state <= StDone;
                    end
                end
                StDone: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign o_cmd_ready   = (r_state == StIdle);
    assign o_busy        = (r_state != StIdle);
    assign o_done        = (r_state == StDone);
    assign o_fifo_rinc   = w_rinc;
    assign o_out_valid   = (r_buf_cnt != 2'd0);
    assign o_out_data    = r_buf[r_head];
    assign o_drained_cnt = r_drained;

endmodule

// File: tb/tb_fv_fifo_drain.sv
// Directed bench for fv_fifo_drain with a behavioural registered-read FIFO in front of it.
module tb_fv_fifo_drain;

    logic        wclk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic [15:0] cmd_len;
    logic        cmd_ready;
    logic        fifo_rempty;
    logic        fifo_rinc;
    logic [31:0] fifo_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        busy;
    logic        done;
    logic [15:0] drained_cnt;

    always #5 wclk = ~wclk;

    fv_fifo_drain #(.LEN_W(16), .DATA_W(32)) dut (
        .wclk          (wclk),
        .rst           (rst),
        .i_cmd_valid   (cmd_valid),
        .i_cmd_len     (cmd_len),
        .o_cmd_ready   (cmd_ready),
        .i_fifo_rempty (fifo_rempty),
        .o_fifo_rinc   (fifo_rinc),
        .i_fifo_rdata  (fifo_rdata),
        .o_out_valid   (out_valid),
        .i_out_ready   (out_ready),
        .o_out_data    (out_data),
        .o_busy        (busy),
        .o_done        (done),
        .o_drained_cnt (drained_cnt)
    );

    // FIFO model: registered read, outputs 0 when not reading
    logic [31:0] mem [64];
    int wp = 0;
    int rp = 0;
    assign fifo_rempty = (wp == rp);

    always @(posedge wclk) begin
        if (rst) begin
            rp         <= 0;
            fifo_rdata <= '0;
        end else if (fifo_rinc && (wp != rp)) begin
            fifo_rdata <= mem[rp[5:0]];
            rp         <= rp + 1;
        end else begin
            fifo_rdata <= '0;
        end
    end

    // Monitor, sampled on the falling edge
    int          cyc = 0;
    int          rinc_cnt, rinc_bad, done_cnt, done_cyc, hold_bad;
    int          rinc_cyc[$];
    int          pop_cyc[$];
    logic [31:0] got_q[$];
    logic        held_v = 1'b0;
    logic [31:0] held_d;

    always @(posedge wclk) cyc <= cyc + 1;

    always @(negedge wclk) begin
        if (rst) begin
            held_v = 1'b0;
        end else begin
            if (fifo_rinc) begin
                rinc_cnt++;
                rinc_cyc.push_back(cyc);
            end
            if (fifo_rinc && fifo_rempty) rinc_bad++;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (out_valid && out_ready) begin
                got_q.push_back(out_data);
                pop_cyc.push_back(cyc);
            end
            if (held_v && !(out_valid && out_data == held_d)) hold_bad++;
            held_v = out_valid && !out_ready;
            held_d = out_data;
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge wclk);
        #1;
    endtask

    task automatic push(input logic [31:0] d);
        mem[wp[5:0]] = d;
        wp++;
    endtask

    task automatic clear_logs();
        rinc_cnt = 0;
        rinc_bad = 0;
        done_cnt = 0;
        done_cyc = 0;
        hold_bad = 0;
        rinc_cyc.delete();
        pop_cyc.delete();
        got_q.delete();
    endtask

    task automatic issue(input logic [15:0] len);
        cmd_valid = 1'b1;
        cmd_len   = len;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int k = 0;
        while (done_cnt == 0 && k < budget) begin
            step();
            k++;
        end
        chk({tag, "_done_seen"}, 32'(done_cnt != 0), 32'd1);
    endtask

    task automatic chk_stream(input string tag, input logic [31:0] base, input int n);
        chk({tag, "_count"}, 32'(got_q.size()), 32'(n));
        for (int i = 0; i < n && i < got_q.size(); i++) begin
            chk($sformatf("%s_data%0d", tag, i), got_q[i], base + 32'(i));
        end
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_len   = '0;
        out_ready = 1'b1;
        clear_logs();
        step();
        step();

        // Reset state
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_rinc", 32'(fifo_rinc), 32'd0);
        chk("rst_drained", 32'(drained_cnt), 32'd0);
        rst = 1'b0;
        step();

        // 1: four preloaded entries, downstream always ready
        clear_logs();
        for (int i = 0; i < 4; i++) push(32'hA0 + 32'(i));
        issue(16'd4);
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_cmd_ready", 32'(cmd_ready), 32'd0);
        wait_done(40, "t1");
        chk("t1_rinc_cnt", 32'(rinc_cnt), 32'd4);
        if (rinc_cyc.size() == 4) chk("t1_rinc_consec", 32'(rinc_cyc[3] - rinc_cyc[0]), 32'd3);
        chk_stream("t1", 32'hA0, 4);
        if (pop_cyc.size() == 4) begin
            chk("t1_b2b", 32'(pop_cyc[3] - pop_cyc[0]), 32'd3);
            chk("t1_done_after_d", 32'(done_cyc), 32'(pop_cyc[3] + 1));
        end
        chk("t1_drained", 32'(drained_cnt), 32'd4);
        step();

        // 2: zero-length command
        clear_logs();
        issue(16'd0);
        chk("t2_done", 32'(done), 32'd1);
        chk("t2_cmd_ready_low", 32'(cmd_ready), 32'd0);
        step();
        chk("t2_done_clear", 32'(done), 32'd0);
        chk("t2_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("t2_rinc_cnt", 32'(rinc_cnt), 32'd0);
        chk("t2_drained", 32'(drained_cnt), 32'd0);

        // 3: eight entries, out_ready pattern 1,0,0 repeating
        clear_logs();
        for (int i = 0; i < 8; i++) push(32'h30 + 32'(i));
        issue(16'd8);
        for (int k = 0; k < 80 && done_cnt == 0; k++) begin
            out_ready = (k % 3 == 0);
            step();
        end
        out_ready = 1'b1;
        chk("t3_done_seen", 32'(done_cnt != 0), 32'd1);
        chk_stream("t3", 32'h30, 8);
        chk("t3_hold", 32'(hold_bad), 32'd0);
        chk("t3_rinc_cnt", 32'(rinc_cnt), 32'd8);
        step();

        // 4: empty FIFO, one write every 5 cycles
        begin
            int pushed = 0;
            int busy_low = 0;
            clear_logs();
            issue(16'd3);
            for (int k = 0; k < 60 && done_cnt == 0; k++) begin
                if (!busy) busy_low++;
                if (k % 5 == 4 && pushed < 3) begin
                    push(32'h40 + 32'(pushed));
                    pushed++;
                end
                step();
            end
            chk("t4_done_seen", 32'(done_cnt != 0), 32'd1);
            chk("t4_busy_held", 32'(busy_low), 32'd0);
            chk("t4_rinc_empty", 32'(rinc_bad), 32'd0);
            chk_stream("t4", 32'h40, 3);
            step();
        end

        // 5: six entries present, drain two
        clear_logs();
        for (int i = 0; i < 6; i++) push(32'h50 + 32'(i));
        issue(16'd2);
        wait_done(30, "t5");
        for (int k = 0; k < 5; k++) step();
        chk("t5_rinc_cnt", 32'(rinc_cnt), 32'd2);
        chk("t5_remaining", 32'(wp - rp), 32'd4);
        chk("t5_done_once", 32'(done_cnt), 32'd1);
        chk_stream("t5", 32'h50, 2);

        // 6: reset mid-burst while a read is in flight and the buffer holds data
        rst = 1'b1;
        wp  = 0;
        step();
        rst = 1'b0;
        step();
        clear_logs();
        for (int i = 0; i < 4; i++) push(32'h70 + 32'(i));
        out_ready = 1'b0;
        issue(16'd4);
        step();
        step();
        rst = 1'b1;
        wp  = 0;
        step();
        chk("t6_out_valid", 32'(out_valid), 32'd0);
        chk("t6_out_data", out_data, 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("t6_done", 32'(done), 32'd0);
        chk("t6_drained", 32'(drained_cnt), 32'd0);
        chk("t6_rinc", 32'(fifo_rinc), 32'd0);
        rst       = 1'b0;
        out_ready = 1'b1;
        step();
        clear_logs();
        push(32'h60);
        push(32'h61);
        issue(16'd2);
        wait_done(30, "t6");
        chk_stream("t6", 32'h60, 2);
        chk("t6_drained_after", 32'(drained_cnt), 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
